// File: rtl/ov7670_frame_ctrl_if.sv
// Control, capture-side and frame-buffer-side signals of the OV7670 frame sequencer.
// Pure wiring with no storage, so it adds no latency.
// There is no backpressure here: the capture stream is strobe-driven and the frame buffer always accepts writes.
interface ov7670_frame_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12,
    parameter int FCNT_W = 8
);
    // software control
    logic              start;
    logic              stop;
    logic              mode;
    // capture side
    logic              cap_vsync;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_dout;
    // frame-buffer write port
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_din;
    // status
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [FCNT_W-1:0] frame_count;
    logic [ADDR_W:0]   last_pixels;

    // The master drives control and capture traffic and observes the frame-buffer port and status.
    modport master (
        output start, stop, mode, cap_vsync, cap_we, cap_addr, cap_dout,
        input  fb_we, fb_addr, fb_din, busy, frame_done, frame_err, frame_count, last_pixels
    );

    // The slave is the sequencer itself.
    modport slave (
        input  start, stop, mode, cap_vsync, cap_we, cap_addr, cap_dout,
        output fb_we, fb_addr, fb_din, busy, frame_done, frame_err, frame_count, last_pixels
    );
endinterface

// File: rtl/ov7670_frame_ctrl.sv
// Frame-level sequencer: gates OV7670 pixel writes into the frame buffer on whole-frame boundaries.
// The write path (fb_we/fb_addr/fb_din) follows cap_* by exactly 1 pclk.
// There is no backpressure: writes are dropped outside CAPTURE and once EXP_PIXELS is reached.
module ov7670_frame_ctrl #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int EXP_PIXELS = 307200,
    parameter int FCNT_W     = 8
) (
    input  logic                      pclk,
    input  logic                      rst,
    ov7670_frame_ctrl_if.slave        bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  EXP_CNT  = CNT_W'(EXP_PIXELS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             vsync_q;
    logic             vs_fall;
    logic             vs_rise;
    logic             mode_q;
    logic             stop_pend;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_cnt_inc;
    logic [CNT_W-1:0] final_cnt;
    logic             in_capture;
    logic             under_limit;

    // The previous vsync level is kept so frame boundaries can be seen as edges.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= bus.cap_vsync;
        end
    end

    // Vsync edge detection, saturating pixel count and the count a frame would close with this cycle.
    always_comb begin
        vs_fall     = vsync_q & ~bus.cap_vsync;
        vs_rise     = ~vsync_q & bus.cap_vsync;
        pix_cnt_inc = (pix_cnt == {CNT_W{1'b1}}) ? pix_cnt : (pix_cnt + CNT_ONE);
        // A pixel arriving on the closing edge still belongs to the frame.
        final_cnt   = bus.cap_we ? pix_cnt_inc : pix_cnt;
        in_capture  = (state == ST_CAPTURE);
        under_limit = (pix_cnt < EXP_CNT);
    end

    // State register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arm on start, open on vsync fall, close on vsync rise.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                // A stop in the same cycle as start is simply dropped.
                if (bus.start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (vs_fall) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A stop landing on the closing edge itself still ends the run.
                if (vs_rise) begin
                    if (mode_q && !stop_pend && !bus.stop) begin
                        state_nxt = ST_ARM;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: busy covers both the armed wait and the active frame.
    always_comb begin
        bus.busy = (state == ST_ARM) || (state == ST_CAPTURE);
    end

    // Run configuration: mode is latched only when a start is accepted, and stop is remembered until frame end.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                mode_q    <= bus.mode;
                stop_pend <= 1'b0;
            end else if (in_capture && bus.stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Pixel counter: cleared when a frame opens and advanced on every capture strobe inside it.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else begin
            if (state == ST_ARM && !bus.stop && vs_fall) begin
                pix_cnt <= '0;
            end else if (in_capture && bus.cap_we) begin
                pix_cnt <= pix_cnt_inc;
            end
        end
    end

    // Registered write port: address and data always track, and the enable opens only inside a frame below the limit.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_din  <= '0;
        end else begin
            bus.fb_we   <= in_capture && bus.cap_we && under_limit;
            bus.fb_addr <= bus.cap_addr;
            bus.fb_din  <= bus.cap_dout;
        end
    end

    // End-of-frame reporting: single-cycle done/err pulses plus a sticky count of the last frame.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.frame_count <= '0;
            bus.last_pixels <= '0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (in_capture && vs_rise) begin
                bus.frame_done  <= 1'b1;
                bus.frame_err   <= (final_cnt != EXP_CNT);
                bus.last_pixels <= final_cnt;
                bus.frame_count <= bus.frame_count + FCNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Directed bench for ov7670_frame_ctrl with EXP_PIXELS=16 and FCNT_W=2.
// Expected pixel writes and frame reports are queued as stimulus is driven.
// A negedge monitor pops and compares them whenever the DUT produces output.
module tb_ov7670_frame_ctrl;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int EXP    = 16;
    localparam int FCNT_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic              err;
        logic [ADDR_W:0]   pixels;
        logic [FCNT_W-1:0] count;
    } done_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    ov7670_frame_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FCNT_W(FCNT_W)) bus ();

    ov7670_frame_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EXP_PIXELS(EXP), .FCNT_W(FCNT_W)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int passes = 0;
    wr_t   wq[$];
    done_t dq[$];
    logic [FCNT_W-1:0] exp_fc = '0;
    logic [ADDR_W-1:0] base   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor, sampled on the falling edge away from DUT updates.
    always @(negedge pclk) begin
        if (!rst) begin
            if (bus.fb_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_fb_we", 32'(bus.fb_addr), 32'hffff_ffff);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("fb_addr", 32'(bus.fb_addr), 32'(w.addr));
                    chk("fb_din", 32'(bus.fb_din), 32'(w.data));
                end
            end
            if (bus.frame_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_frame_done", 32'(bus.last_pixels), 32'hffff_ffff);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("frame_err", 32'(bus.frame_err), 32'(d.err));
                    chk("last_pixels", 32'(bus.last_pixels), 32'(d.pixels));
                    chk("frame_count", 32'(bus.frame_count), 32'(d.count));
                end
            end else if (bus.frame_err) begin
                chk("frame_err_without_done", 32'(bus.frame_err), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wq.delete();
        dq.delete();
        exp_fc = '0;
        tick();
    endtask

    task automatic pulse_start(input logic m);
        bus.start = 1'b1;
        bus.mode  = m;
        tick();
        bus.start = 1'b0;
        bus.mode  = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    // One vsync-low frame of n pixel strobes; cap says whether the sequencer is expected to capture it.
    task automatic frame(input int n, input bit cap, input bit coinc,
                         input int start_at, input int stop_at, input bit smode);
        bus.cap_vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == start_at) pulse_start(smode);
            if (i == stop_at) pulse_stop();
            if (coinc && i == n - 1) bus.cap_vsync = 1'b1;
            bus.cap_we   = 1'b1;
            bus.cap_addr = base + ADDR_W'(i);
            bus.cap_dout = DATA_W'($urandom_range(0, 4095));
            if (cap && i < EXP) wq.push_back('{addr: bus.cap_addr, data: bus.cap_dout});
            tick();
            bus.cap_we = 1'b0;
        end
        if (!coinc) begin
            bus.cap_vsync = 1'b1;
            tick();
        end
        if (cap) begin
            exp_fc = exp_fc + 1'b1;
            dq.push_back('{err: (n != EXP), pixels: (ADDR_W+1)'(n), count: exp_fc});
        end
        base = base + ADDR_W'(64);
        tick();
        tick();
        tick();
    endtask

    task automatic drained(input string tag);
        chk({tag, "_writes_drained"}, 32'(wq.size()), 32'd0);
        chk({tag, "_dones_drained"}, 32'(dq.size()), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.cap_vsync = 1'b1; bus.cap_we = 1'b0;
        bus.cap_addr = '0; bus.cap_dout = '0;
        tick();
        do_reset();

        // reset state
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
        chk("rst_last_pixels", 32'(bus.last_pixels), 32'd0);

        // 1: single-shot exact frame
        pulse_start(1'b0);
        chk("t1_busy_armed", 32'(bus.busy), 32'd1);
        frame(16, 1, 0, -1, -1, 0);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);
        chk("t1_count", 32'(bus.frame_count), 32'd1);
        drained("t1");

        // 2: arm in the middle of a frame; that frame is skipped, the next is captured
        do_reset();
        frame(16, 0, 0, 5, -1, 0);
        frame(16, 1, 0, -1, -1, 0);
        chk("t2_count", 32'(bus.frame_count), 32'd1);
        drained("t2");

        // 3: overrun then short frame (last pixel coincident with vsync rise), continuous then stop
        do_reset();
        pulse_start(1'b1);
        frame(20, 1, 0, -1, -1, 0);
        frame(10, 1, 1, -1, 5, 0);
        chk("t3_busy_after", 32'(bus.busy), 32'd0);
        drained("t3");

        // 4: continuous for three frames, stop during the third, fourth not written
        do_reset();
        pulse_start(1'b1);
        frame(16, 1, 0, -1, -1, 0);
        frame(16, 1, 0, -1, -1, 0);
        frame(16, 1, 0, -1, 8, 0);
        chk("t4_busy_after", 32'(bus.busy), 32'd0);
        frame(16, 0, 0, -1, -1, 0);
        chk("t4_count", 32'(bus.frame_count), 32'd3);
        drained("t4");

        // 5: stop while armed, then start while capturing
        pulse_start(1'b1);
        pulse_stop();
        chk("t5_busy_after_stop", 32'(bus.busy), 32'd0);
        frame(16, 0, 0, -1, -1, 0);
        pulse_start(1'b0);
        frame(16, 1, 0, 4, -1, 1);
        chk("t5_busy_single", 32'(bus.busy), 32'd0);
        frame(16, 0, 0, -1, -1, 0);
        chk("t5_count", 32'(bus.frame_count), 32'd0);
        drained("t5");

        // 6: asynchronous reset after 7 pixels, then frame-counter wrap
        pulse_start(1'b0);
        bus.cap_vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.cap_we   = 1'b1;
            bus.cap_addr = base + ADDR_W'(i);
            bus.cap_dout = DATA_W'($urandom_range(0, 4095));
            wq.push_back('{addr: bus.cap_addr, data: bus.cap_dout});
            tick();
            bus.cap_we = 1'b0;
        end
        chk("t6_fb_we_before", 32'(bus.fb_we), 32'd1);
        @(negedge pclk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_fb_we_async", 32'(bus.fb_we), 32'd0);
        chk("t6_busy_async", 32'(bus.busy), 32'd0);
        chk("t6_count_async", 32'(bus.frame_count), 32'd0);
        chk("t6_last_async", 32'(bus.last_pixels), 32'd0);
        chk("t6_writes_drained", 32'(wq.size()), 32'd0);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        exp_fc = '0;
        bus.cap_vsync = 1'b1;
        base = base + ADDR_W'(64);
        tick();
        for (int f = 0; f < 4; f++) begin
            pulse_start(1'b0);
            frame(16, 1, 0, -1, -1, 0);
        end
        chk("t6_count_wrapped", 32'(bus.frame_count), 32'd0);
        chk("t6_busy_end", 32'(bus.busy), 32'd0);
        drained("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
